control_pipe: RTL and testbench

- Registered, parametrised successor of the combinational MIPS control decoder.
- Decodes R-type (add/sub/and/or/mul), load and store into the same 32-bit control word layout.
- Adds valid/ready handshakes on both sides, a multi-cycle multiplier stall, one-bubble load-use hazard detection and an illegal-instruction flag.
- Sits between the instruction fetch register and the register-file/ALU/data-memory datapath.

---
 rtl/control_pipe.sv | 196 +++++++++++++++++++
 tb/tb_control_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Registered MIPS control decoder: valid/ready on both sides, a multi-cycle
// multiplier stall, a one-bubble load-use hazard and an illegal-instruction flag.
module control_pipe #(
    parameter int unsigned CTRL_W     = 32,
    parameter int unsigned MUL_CYCLES = 3,
    parameter logic [5:0]  OP_RTYPE   = 6'd1,
    parameter logic [5:0]  OP_LOAD    = 6'd2,
    parameter logic [5:0]  OP_STORE   = 6'd3,
    parameter logic [4:0]  SHAMT_TAG  = 5'd10,
    parameter bit          HAZARD_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] output_control,
    output logic              out_illegal,
    output logic              busy
);

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_MUL = 6'd50;

    localparam int unsigned      CNT_W        = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
    localparam int unsigned      CNT_LOAD_INT = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(CNT_LOAD_INT);
    localparam bit               MUL_STALL    = (MUL_CYCLES > 1);

    typedef enum logic {
        IDLE,
        MUL_WAIT
    } state_e;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign shamt  = instruction[10:6];
    assign funct  = instruction[5:0];

    logic [CTRL_W-1:0] dec_word;
    logic              dec_illegal;
    logic              dec_mul;
    logic              dec_load;
    logic              dec_rs_used;
    logic              dec_rt_used;
    logic              rtype_ok;
    logic [1:0]        alu_sel;
    logic              d_sel;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        dec_word    = '0;
        dec_illegal = 1'b1;
        dec_mul     = 1'b0;
        dec_load    = 1'b0;
        dec_rs_used = 1'b0;
        dec_rt_used = 1'b0;
        rtype_ok    = 1'b0;
        alu_sel     = 2'd0;
        d_sel       = 1'b0;

        case (funct)
            FN_ADD:  begin rtype_ok = 1'b1; alu_sel = 2'd0; end
            FN_SUB:  begin rtype_ok = 1'b1; alu_sel = 2'd1; end
            FN_AND:  begin rtype_ok = 1'b1; alu_sel = 2'd2; end
            FN_OR:   begin rtype_ok = 1'b1; alu_sel = 2'd3; end
            FN_MUL:  begin rtype_ok = 1'b1; d_sel   = 1'b1; end
            default: ;
        endcase

        if (opcode == OP_RTYPE && shamt == SHAMT_TAG && rtype_ok) begin
            dec_illegal     = 1'b0;
            dec_mul         = d_sel;
            dec_rs_used     = 1'b1;
            dec_rt_used     = 1'b1;
            dec_word[22]    = 1'b1;
            dec_word[21:17] = rs;
            dec_word[16:12] = rt;
            dec_word[11:7]  = rd;
            dec_word[5]     = d_sel;
            dec_word[4:3]   = alu_sel;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
            // Store mirrors load (immediate ALU operand, chip select) but writes memory, not the regfile.
            dec_illegal     = 1'b0;
            dec_load        = (opcode == OP_LOAD);
            dec_rs_used     = 1'b1;
            dec_rt_used     = (opcode == OP_STORE);
            dec_word[22]    = (opcode == OP_LOAD);
            dec_word[21:17] = rs;
            dec_word[16:12] = rt;
            dec_word[11:7]  = rt;
            dec_word[6]     = 1'b1;
            dec_word[2]     = 1'b1;
            dec_word[1]     = (opcode == OP_STORE);
            dec_word[0]     = 1'b1;
        end
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        ld_rt_q, ld_rt_d;
    logic              ld_fresh_q, ld_fresh_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;

    logic hazard;
    logic accept;

    // Only a load accepted on the previous edge can cause a bubble; illegal words never match.
    assign hazard = HAZARD_EN && ld_fresh_q && in_valid && (ld_rt_q != 5'd0) &&
                    ((dec_rs_used && rs == ld_rt_q) || (dec_rt_used && rt == ld_rt_q));

    assign in_ready = (!valid_q || out_ready) && (state_q == IDLE) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && dec_mul && MUL_STALL) begin
                    state_d = MUL_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        ld_rt_d    = ld_rt_q;
        ld_fresh_d = accept && dec_load;
        if (accept) begin
            valid_d   = 1'b1;
            ctrl_d    = dec_word;
            illegal_d = dec_illegal;
            if (dec_load) begin
                ld_rt_d = rt;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ld_rt_q    <= 5'd0;
            ld_fresh_q <= 1'b0;
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_rt_q    <= ld_rt_d;
            ld_fresh_q <= ld_fresh_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out_valid      = valid_q;
    assign output_control = ctrl_q;
    assign out_illegal    = illegal_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: a cycle-level reference model predicts
// in_ready/busy and queues expected words; a monitor checks each delivered word.
module tb_control_pipe;

    localparam int CTRL_W     = 32;
    localparam int MUL_CYCLES = 3;

    localparam logic [31:0] I_ADD   = 32'h044322A0;
    localparam logic [31:0] I_ADD5  = 32'h04A322A0;
    localparam logic [31:0] I_LOAD  = 32'h08250008;
    localparam logic [31:0] I_STORE = 32'h0C250008;
    localparam logic [31:0] I_MUL   = 32'h044322B2;
    localparam logic [31:0] I_BADFN = 32'h04432280;
    localparam logic [31:0] I_BADOP = 32'hFC000000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [31:0]       instruction;
    logic              out_ready;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] output_control;
    logic              out_illegal;
    logic              busy;

    logic              in_ready2;
    logic              out_valid2;
    logic [CTRL_W-1:0] output_control2;
    logic              out_illegal2;
    logic              busy2;

    always #5 clk = ~clk;

    control_pipe #(.CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .output_control(output_control), .out_illegal(out_illegal), .busy(busy)
    );

    control_pipe #(.CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES), .HAZARD_EN(1'b0)) dut_nohaz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .instruction(instruction), .out_valid(out_valid2), .out_ready(1'b1),
        .output_control(output_control2), .out_illegal(out_illegal2), .busy(busy2)
    );

    typedef enum {K_ILL, K_ALU, K_MUL, K_LOAD, K_STORE} kind_e;
    typedef struct {
        logic [31:0] word;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    bit   m_out_full;
    int   m_mul_block;
    int   m_ld_rt;
    logic seen_rdy1;
    logic seen_rdy2;
    logic seen_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] ins);
        int op, fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (op == 1 && ins[10:6] == 5'd10) begin
            if (fn == 32 || fn == 34 || fn == 36 || fn == 37) return K_ALU;
            if (fn == 50) return K_MUL;
            return K_ILL;
        end
        if (op == 2) return K_LOAD;
        if (op == 3) return K_STORE;
        return K_ILL;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] ins);
        int rs, rt, rd, fn, alu, w;
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        fn = int'(ins[5:0]);
        alu = (fn == 34) ? 1 : (fn == 36) ? 2 : (fn == 37) ? 3 : 0;
        case (classify(ins))
            K_ALU:   w = (1 << 22) + rs * 131072 + rt * 4096 + rd * 128 + alu * 8;
            K_MUL:   w = (1 << 22) + rs * 131072 + rt * 4096 + rd * 128 + 32;
            K_LOAD:  w = (1 << 22) + rs * 131072 + rt * 4096 + rt * 128 + 64 + 4 + 1;
            K_STORE: w = rs * 131072 + rt * 4096 + rt * 128 + 64 + 4 + 2 + 1;
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, sh;
        int sel, fsel;
        sel  = int'($urandom_range(0, 9));
        rs   = 5'($urandom_range(0, 3));
        rt   = 5'($urandom_range(0, 3));
        rd   = 5'($urandom_range(0, 31));
        sh   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd10;
        fsel = int'($urandom_range(0, 5));
        case (fsel)
            0: fn = 6'd32;
            1: fn = 6'd34;
            2: fn = 6'd36;
            3: fn = 6'd37;
            4: fn = 6'd50;
            default: fn = 6'($urandom);
        endcase
        if (sel < 6)       op = 6'd1;
        else if (sel < 8)  op = 6'd2;
        else if (sel == 8) op = 6'd3;
        else               op = 6'($urandom);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    task automatic model_reset();
        m_out_full  = 1'b0;
        m_mul_block = 0;
        m_ld_rt     = -1;
        sb.delete();
    endtask

    // One clock of stimulus: called just after a rising edge, returns just after the next one.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
        kind_e k;
        bit    haz, exp_rdy, acc;
        in_valid    = v;
        instruction = ins;
        out_ready   = ordy;
        @(negedge clk);
        k   = classify(ins);
        haz = v && m_ld_rt > 0 &&
              ((k != K_ILL && int'(ins[25:21]) == m_ld_rt) ||
               ((k == K_ALU || k == K_MUL || k == K_STORE) && int'(ins[20:16]) == m_ld_rt));
        exp_rdy = (!m_out_full || ordy) && m_mul_block == 0 && !haz;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(m_mul_block > 0));
        seen_rdy1 = in_ready;
        seen_rdy2 = in_ready2;
        seen_busy = busy;
        acc = v && exp_rdy;
        if (acc) sb.push_back('{word: ref_word(ins), ill: (k == K_ILL)});
        m_out_full  = acc ? 1'b1 : (ordy ? 1'b0 : m_out_full);
        m_mul_block = (acc && k == K_MUL) ? MUL_CYCLES - 1 : ((m_mul_block > 0) ? m_mul_block - 1 : 0);
        m_ld_rt     = (acc && k == K_LOAD) ? int'(ins[20:16]) : -1;
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        bit          hold;
        logic [31:0] hold_word;
        logic        hold_ill;
        exp_t        e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_word", output_control, hold_word);
                check("hold_illegal", 32'(out_illegal), 32'(hold_ill));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got word 0x%08h, expected no output", output_control);
                end else begin
                    e = sb.pop_front();
                    check("word", output_control, e.word);
                    check("illegal", 32'(out_illegal), 32'(e.ill));
                end
            end
            hold      = out_valid && !out_ready;
            hold_word = output_control;
            hold_ill  = out_illegal;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        out_ready   = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_word", output_control, 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // add, one-cycle latency
        step(1'b1, I_ADD, 1'b1);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_word", output_control, 32'h00443200);
        check("add_illegal", 32'(out_illegal), 32'd0);
        step(1'b0, '0, 1'b1);

        // load-use: one bubble with hazard detection, none without
        step(1'b1, I_LOAD, 1'b1);
        check("load_word", output_control, 32'h004252C5);
        step(1'b1, I_ADD5, 1'b1);
        check("hazard_stall", 32'(seen_rdy1), 32'd0);
        check("nohaz_ready", 32'(seen_rdy2), 32'd1);
        step(1'b1, I_ADD5, 1'b1);
        check("hazard_release", 32'(seen_rdy1), 32'd1);
        step(1'b0, '0, 1'b1);

        // mul: two stall cycles with busy high
        step(1'b1, I_MUL, 1'b1);
        check("mul_word", output_control, 32'h00443220);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, I_ADD, 1'b1);
            check("mul_stall_ready", 32'(seen_rdy1), 32'(i == 2));
            check("mul_stall_busy", 32'(seen_busy), 32'(i != 2));
        end

        // illegal words: zero word, flag set, no stall
        step(1'b1, I_BADFN, 1'b1);
        check("badfn_word", output_control, 32'd0);
        check("badfn_illegal", 32'(out_illegal), 32'd1);
        step(1'b1, I_BADOP, 1'b1);
        check("badop_nostall", 32'(seen_rdy1), 32'd1);
        check("badop_word", output_control, 32'd0);
        check("badop_illegal", 32'(out_illegal), 32'd1);
        step(1'b1, I_ADD, 1'b1);
        check("after_illegal_ready", 32'(seen_rdy1), 32'd1);

        // store under backpressure
        step(1'b1, I_STORE, 1'b1);
        check("store_word", output_control, 32'h000252C7);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, I_ADD, 1'b0);
            check("bp_in_ready", 32'(seen_rdy1), 32'd0);
        end
        step(1'b1, I_ADD, 1'b1);
        check("bp_release", 32'(seen_rdy1), 32'd1);
        step(1'b0, '0, 1'b1);

        // reset in the middle of MUL_WAIT
        step(1'b1, I_MUL, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_word", output_control, 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 9) < 7));
        end

        repeat (4) step(1'b0, '0, 1'b1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
